// File: rtl/mem_wb_stage.sv
// EXE/MEM register, data memory, MEM/WB register and write-back mux.
// Optional alignment checking is enabled by DMEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DMEM_DEPTH = 1024,
  parameter int DMEM_AW    = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] EXE_Result,
  input  logic [31:0] EXE_B,
  input  logic [4:0]  EXE_Rw,
  input  logic        EXE_RegWr,
  input  logic        EXE_MemWr,
  input  logic        EXE_MemtoReg,
  output logic [31:0] MEM_Result,
  output logic [4:0]  MEM_Rw,
  output logic        MEM_RegWr,
  output logic        MEM_MemtoReg,
  output logic [4:0]  WB_Rw,
  output logic        WB_RegWr,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic [31:0] WB_BusW,
  output logic        MEM_AlignErr
`else
  output logic [31:0] WB_BusW
`endif
);

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] b;
    logic [4:0]  rw;
    logic        regwr;
    logic        memwr;
    logic        memtoreg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] memdata;
    logic [4:0]  rw;
    logic        regwr;
    logic        memtoreg;
  } mem_wb_t;

  ex_mem_t ex_mem;
  ex_mem_t ex_mem_d;
  mem_wb_t mem_wb;
  mem_wb_t mem_wb_d;

  logic [31:0]        dmem [DMEM_DEPTH];
  logic [DMEM_AW-1:0] idx;
  logic [31:0]        rdata;
  logic               align_err;
  logic               st_en;
  logic               unused_addr;

  assign idx   = ex_mem.result[DMEM_AW+1:2];
  assign rdata = dmem[idx];

  assign unused_addr = ^{ex_mem.result[31:DMEM_AW+2],
                         ex_mem.result[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (ex_mem.memwr | ex_mem.memtoreg)
                   & (ex_mem.result[1:0] != 2'b00);
  assign MEM_AlignErr = align_err;
`else
  assign align_err = 1'b0;
`endif

  // Writes to $0 are dropped at entry so they are never forwarded.
  always_comb begin
    ex_mem_d          = '0;
    ex_mem_d.result   = EXE_Result;
    ex_mem_d.b        = EXE_B;
    ex_mem_d.rw       = EXE_Rw;
    ex_mem_d.regwr    = EXE_RegWr & (EXE_Rw != 5'd0);
    ex_mem_d.memwr    = EXE_MemWr;
    ex_mem_d.memtoreg = EXE_MemtoReg;
  end

  always_comb begin
    mem_wb_d          = '0;
    mem_wb_d.result   = ex_mem.result;
    mem_wb_d.memdata  = rdata;
    mem_wb_d.rw       = ex_mem.rw;
    mem_wb_d.regwr    = ex_mem.regwr
                      & ~(align_err & ex_mem.memtoreg);
    mem_wb_d.memtoreg = ex_mem.memtoreg;
  end

  assign st_en = ex_mem.memwr & Rst_n & ~align_err;

  always_ff @(posedge Clk) begin
    if (st_en) begin
      dmem[idx] <= ex_mem.b;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
    end
  end

  assign MEM_Result   = ex_mem.result;
  assign MEM_Rw       = ex_mem.rw;
  assign MEM_RegWr    = ex_mem.regwr;
  assign MEM_MemtoReg = ex_mem.memtoreg;
  assign WB_Rw        = mem_wb.rw;
  assign WB_RegWr     = mem_wb.regwr;
  assign WB_BusW      = mem_wb.memtoreg ? mem_wb.memdata
                                        : mem_wb.result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors, queued
// expectations tagged with the cycle they must appear in.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] exe_result;
  logic [31:0] exe_b;
  logic [4:0]  exe_rw;
  logic        exe_regwr;
  logic        exe_memwr;
  logic        exe_memtoreg;
  logic [31:0] mem_result;
  logic [4:0]  mem_rw;
  logic        mem_regwr;
  logic        mem_memtoreg;
  logic [4:0]  wb_rw;
  logic        wb_regwr;
  logic [31:0] wb_busw;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        mem_alignerr;
`endif

  mem_wb_stage #(.DMEM_DEPTH(1024), .DMEM_AW(10)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .EXE_Result   (exe_result),
    .EXE_B        (exe_b),
    .EXE_Rw       (exe_rw),
    .EXE_RegWr    (exe_regwr),
    .EXE_MemWr    (exe_memwr),
    .EXE_MemtoReg (exe_memtoreg),
    .MEM_Result   (mem_result),
    .MEM_Rw       (mem_rw),
    .MEM_RegWr    (mem_regwr),
    .MEM_MemtoReg (mem_memtoreg),
    .WB_Rw        (wb_rw),
    .WB_RegWr     (wb_regwr),
`ifdef DMEM_ALIGN_CHECK_EN
    .WB_BusW      (wb_busw),
    .MEM_AlignErr (mem_alignerr)
`else
    .WB_BusW      (wb_busw)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: return mem_result;
      1: return {27'b0, mem_rw};
      2: return {31'b0, mem_regwr};
      3: return {31'b0, mem_memtoreg};
      4: return {27'b0, wb_rw};
      5: return {31'b0, wb_regwr};
      6: return wb_busw;
`ifdef DMEM_ALIGN_CHECK_EN
      7: return {31'b0, mem_alignerr};
`endif
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge Clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [31:0] act;
        act = probe(q[i].sel);
        checks++;
        if (q[i].cyc < cyc || act !== q[i].exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %h expected %h",
                   q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(int c, int sel, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_zero(int c, string t);
    push(c, 0, 32'h0, {t, ".mem_result"});
    push(c, 1, 32'h0, {t, ".mem_rw"});
    push(c, 2, 32'h0, {t, ".mem_regwr"});
    push(c, 3, 32'h0, {t, ".mem_memtoreg"});
    push(c, 4, 32'h0, {t, ".wb_rw"});
    push(c, 5, 32'h0, {t, ".wb_regwr"});
    push(c, 6, 32'h0, {t, ".wb_busw"});
`ifdef DMEM_ALIGN_CHECK_EN
    push(c, 7, 32'h0, {t, ".alignerr"});
`endif
  endtask

  task automatic drive(input logic [31:0] res, input logic [31:0] b,
                       input logic [4:0] rw, input logic rwr,
                       input logic mwr, input logic m2r);
    exe_result   = res;
    exe_b        = b;
    exe_rw       = rw;
    exe_regwr    = rwr;
    exe_memwr    = mwr;
    exe_memtoreg = m2r;
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input string t,
                      input logic [31:0] res, input logic [31:0] b,
                      input logic [4:0] rw, input logic rwr,
                      input logic mwr, input logic m2r,
                      input logic e_mrwr, input logic e_wrwr,
                      input logic [31:0] e_busw, input logic e_aerr);
    push(cyc + 1, 0, res, {t, ".mem_result"});
    push(cyc + 1, 1, {27'b0, rw}, {t, ".mem_rw"});
    push(cyc + 1, 2, {31'b0, e_mrwr}, {t, ".mem_regwr"});
    push(cyc + 1, 3, {31'b0, m2r}, {t, ".mem_memtoreg"});
    push(cyc + 2, 4, {27'b0, rw}, {t, ".wb_rw"});
    push(cyc + 2, 5, {31'b0, e_wrwr}, {t, ".wb_regwr"});
    push(cyc + 2, 6, e_busw, {t, ".wb_busw"});
`ifdef DMEM_ALIGN_CHECK_EN
    push(cyc + 1, 7, {31'b0, e_aerr}, {t, ".alignerr"});
`else
    if (e_aerr) begin end
`endif
    drive(res, b, rw, rwr, mwr, m2r);
  endtask

  logic [31:0] mis_word;
  logic        mis_wrwr;

  initial begin
`ifdef DMEM_ALIGN_CHECK_EN
    mis_word = 32'hCAFE_F00D;
    mis_wrwr = 1'b0;
`else
    mis_word = 32'h1234_5678;
    mis_wrwr = 1'b1;
`endif
    Rst_n        = 1'b0;
    exe_result   = 32'h0;
    exe_b        = 32'hDEAD_BEEF;
    exe_rw       = 5'd3;
    exe_regwr    = 1'b1;
    exe_memwr    = 1'b1;
    exe_memtoreg = 1'b0;
    push_zero(1, "rst_a");
    push_zero(2, "rst_b");
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    step("alu", 32'h1234, 32'h0, 5'd5, 1, 0, 0,
         1, 1, 32'h1234, 0);
    step("sw40", 32'h40, 32'hCAFE_F00D, 5'd0, 0, 1, 0,
         0, 0, 32'h40, 0);
    step("lw40", 32'h40, 32'h0, 5'd8, 1, 0, 1,
         1, 1, 32'hCAFE_F00D, 0);
    step("sw_wrap", 32'h1000, 32'hA5A5_A5A5, 5'd0, 0, 1, 0,
         0, 0, 32'h1000, 0);
    step("lw_wrap", 32'h0, 32'h0, 5'd10, 1, 0, 1,
         1, 1, 32'hA5A5_A5A5, 0);
    step("r0", 32'h77, 32'h0, 5'd0, 1, 0, 0,
         0, 0, 32'h77, 0);
    step("b2b_a", 32'h111, 32'h0, 5'd12, 1, 0, 0,
         1, 1, 32'h111, 0);
    step("b2b_b", 32'h222, 32'h0, 5'd12, 1, 0, 0,
         1, 1, 32'h222, 0);
    step("sw80", 32'h80, 32'h0BAD_F00D, 5'd0, 0, 1, 0,
         0, 0, 32'h80, 0);
    step("both", 32'h80, 32'h5555, 5'd13, 1, 1, 1,
         1, 1, 32'h0BAD_F00D, 0);
    step("lw80", 32'h80, 32'h0, 5'd14, 1, 0, 1,
         1, 1, 32'h5555, 0);
    step("sw_mis", 32'h42, 32'h1234_5678, 5'd0, 0, 1, 0,
         0, 0, 32'h42, 1);
    step("lw_al", 32'h40, 32'h0, 5'd15, 1, 0, 1,
         1, 1, mis_word, 0);
    step("lw_mis", 32'h43, 32'h0, 5'd16, 1, 0, 1,
         1, mis_wrwr, mis_word, 1);

    // Reset with a store sitting in MEM must leave word 0 intact.
    step("sw0", 32'h0, 32'h1111_1111, 5'd0, 0, 1, 0,
         0, 0, 32'h0, 0);
    drive(32'h0, 32'hDEAD_BEEF, 5'd3, 1, 1, 0);
    Rst_n = 1'b0;
    push_zero(cyc + 1, "rst2_a");
    push_zero(cyc + 2, "rst2_b");
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    step("lw0", 32'h0, 32'h0, 5'd9, 1, 0, 1,
         1, 1, 32'h1111_1111, 0);

    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge Clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
